// File: rtl/pp_mac.sv
// pp_mac: streaming multiply-accumulate over one ping-pong buffer frame.
// Each frame has NODE elements. An unsigned pixel is multiplied by a signed weight, and the
// products are summed into a signed result.
// Optional feature macro: PP_MAC_RELU_EN clamps a negative frame result to zero.
// Reset: rst is synchronous and active-low.
module pp_mac #(
  parameter int unsigned INPUT  = 8,
  parameter int unsigned NODE   = 784,
  parameter int unsigned AWIDTH = $clog2(NODE),
  parameter int unsigned ACC_W  = 2*INPUT+AWIDTH+1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pingpong_swap,
  input  logic              i_valid,
  input  logic [INPUT-1:0]  i_din,
  input  logic [INPUT-1:0]  wt_data,
  output logic              r_request,
  output logic [AWIDTH-1:0] wt_addr,
  output logic              done_read,
  output logic              res_valid,
  output logic [ACC_W-1:0]  res,
  output logic              busy
);

  // rcv_cnt needs one extra bit so it can hold NODE itself (frame complete).
  localparam int unsigned      CntW    = AWIDTH + 1;
  localparam int unsigned      ProdW   = 2*INPUT + 1;
  localparam logic [AWIDTH-1:0] ReqLast = AWIDTH'(NODE - 1);
  localparam logic [CntW-1:0]   RcvLast = CntW'(NODE - 1);
  localparam logic [CntW-1:0]   RcvFull = CntW'(NODE);

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StReq,
    StDrain,
    StOut
  } state_e;

  state_e                   state_q, state_d;
  logic [AWIDTH-1:0]        req_cnt_q, req_cnt_d;
  logic [CntW-1:0]          rcv_cnt_q, rcv_cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  res_q, res_d;

  // Datapath signals: operands widened to the product width before the multiply.
  logic signed [INPUT:0]    pix_s;
  logic signed [INPUT-1:0]  wt_s;
  logic signed [ProdW-1:0]  pix_x;
  logic signed [ProdW-1:0]  wt_x;
  logic signed [ProdW-1:0]  prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic                     in_window;
  logic                     take;
  logic                     last_beat;
  logic                     rcv_full;

  // Signed product of one element, sign-extended to the accumulator width.
  always_comb begin
    pix_s    = signed'({1'b0, i_din});
    wt_s     = signed'(wt_data);
    pix_x    = ProdW'(pix_s);
    wt_x     = ProdW'(wt_s);
    prod     = pix_x * wt_x;
    prod_ext = ACC_W'(prod);
    acc_sum  = acc_q + prod_ext;
  end

  // Decide whether this cycle's element is accepted into the running sum.
  always_comb begin
    in_window = (state_q == StReq) || (state_q == StDrain);
    rcv_full  = (rcv_cnt_q == RcvFull);
    // Beats beyond NODE are dropped so a misbehaving buffer cannot corrupt the sum.
    take      = i_valid && in_window && !rcv_full;
    last_beat = take && (rcv_cnt_q == RcvLast);
  end

  // Next-state, counter, accumulator and result logic.
  always_comb begin
    state_d   = state_q;
    req_cnt_d = req_cnt_q;
    rcv_cnt_d = rcv_cnt_q;
    acc_d     = acc_q;
    res_d     = res_q;

    if (take) begin
      acc_d     = acc_sum;
      rcv_cnt_d = rcv_cnt_q + CntW'(1);
    end

    unique case (state_q)
      StInit: begin
        state_d = StIdle;
      end
      StIdle: begin
        if (pingpong_swap) begin
          state_d   = StReq;
          req_cnt_d = '0;
          rcv_cnt_d = '0;
          acc_d     = '0;
        end
      end
      StReq: begin
        req_cnt_d = req_cnt_q + AWIDTH'(1);
        if (req_cnt_q == ReqLast) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Leave as soon as the final element lands, however late it arrives.
        if (last_beat || rcv_full) begin
          state_d = StOut;
`ifdef PP_MAC_RELU_EN
          res_d = acc_d[ACC_W-1] ? '0 : acc_d;
`else
          res_d = acc_d;
`endif
        end
      end
      StOut: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  // State and datapath registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StInit;
      req_cnt_q <= '0;
      rcv_cnt_q <= '0;
      acc_q     <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_cnt_q <= req_cnt_d;
      rcv_cnt_q <= rcv_cnt_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    r_request = (state_q == StReq);
    wt_addr   = req_cnt_q;
    res_valid = (state_q == StOut);
    // INIT is held while reset is asserted, so gate its done_read pulse on release.
    done_read = ((state_q == StInit) && rst) || (state_q == StOut);
    busy      = (state_q != StIdle);
    res       = res_q;
  end

endmodule

// File: tb/tb_pp_mac.sv
// Self-checking bench for pp_mac: table of directed frames plus reset corner sequences.
module tb_pp_mac;

  localparam int INPUT  = 8;
  localparam int NODE   = 784;
  localparam int AWIDTH = 10;
  localparam int ACC_W  = 2*INPUT + AWIDTH + 1;

  logic                    clk;
  logic                    rst;
  logic                    pingpong_swap;
  logic                    i_valid;
  logic [INPUT-1:0]        i_din;
  logic [INPUT-1:0]        wt_data;
  logic                    r_request;
  logic [AWIDTH-1:0]       wt_addr;
  logic                    done_read;
  logic                    res_valid;
  logic signed [ACC_W-1:0] res;
  logic                    busy;

  pp_mac #(
    .INPUT (INPUT),
    .NODE  (NODE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pingpong_swap (pingpong_swap),
    .i_valid       (i_valid),
    .i_din         (i_din),
    .wt_data       (wt_data),
    .r_request     (r_request),
    .wt_addr       (wt_addr),
    .done_read     (done_read),
    .res_valid     (res_valid),
    .res           (res),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int     pix;
    int     wt_even;
    int     wt_odd;
    bit     gaps;
    bit     extra_swap;
    longint exp;
  } vec_t;

  typedef struct {
    int t;
    int idx;
  } pend_t;

  vec_t   vecs[6];
  pend_t  pend[$];
  int     gap_pts[3] = '{100, 400, 783};

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;

  int     n_req, addr_err, first_req, n_rv, n_dr, rv_cyc, last_iv_cyc, swap_cyc;
  int     busy_after, n_iv, gi;
  longint res_seen, res_hold;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint exp_of(input vec_t v);
`ifdef PP_MAC_RELU_EN
    return (v.exp < 0) ? 64'sd0 : v.exp;
`else
    return v.exp;
`endif
  endfunction

  // Plays the buffer: 2-cycle read latency, optional idle gaps, optional stray swap.
  task automatic run_frame(input vec_t v, input int abort_at);
    pend_t e;
    int    w;
    int    tail;
    pend.delete();
    n_req = 0; addr_err = 0; first_req = -1; n_rv = 0; n_dr = 0; rv_cyc = -1;
    last_iv_cyc = -1; busy_after = -1; n_iv = 0; gi = 0; tail = -1;
    res_seen = 0; res_hold = 0;
    swap_cyc = cyc;
    pingpong_swap = 1'b1;
    i_valid = 1'b0;
    for (int k = 0; k < 1200; k++) begin
      step();
      pingpong_swap = 1'b0;
      i_valid = 1'b0;
      if (r_request) begin
        if (first_req < 0) first_req = cyc;
        if (int'(wt_addr) != n_req) addr_err++;
        pend.push_back('{t: cyc + 2, idx: n_req});
        n_req++;
      end
      if (res_valid) begin
        n_rv++;
        rv_cyc = cyc;
        res_seen = longint'(res);
        tail = 3;
      end
      if (done_read) n_dr++;
      if (rv_cyc >= 0 && cyc == rv_cyc + 1) busy_after = int'(busy);
      if (abort_at >= 0 && n_req == abort_at) begin
        rst = 1'b0;
        return;
      end
      if (v.extra_swap && n_req == 100) pingpong_swap = 1'b1;
      if (v.gaps && gi < 3 && n_iv == gap_pts[gi] && pend.size() > 0 && pend[0].t <= cyc) begin
        gi++;
      end else if (pend.size() > 0 && pend[0].t <= cyc) begin
        e = pend.pop_front();
        w = (e.idx % 2 == 1) ? v.wt_odd : v.wt_even;
        i_valid = 1'b1;
        i_din = 8'(v.pix);
        wt_data = 8'(w);
        n_iv++;
        last_iv_cyc = cyc;
      end
      if (tail > 0) begin
        tail--;
        if (tail == 0) begin
          res_hold = longint'(res);
          break;
        end
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input vec_t v);
    chk({tag, " req_count"}, n_req, NODE);
    chk({tag, " addr_errors"}, addr_err, 0);
    chk({tag, " first_req_cycle"}, first_req, swap_cyc + 1);
    chk({tag, " res_valid_count"}, n_rv, 1);
    chk({tag, " done_read_count"}, n_dr, 1);
    chk({tag, " res_valid_after_last_beat"}, rv_cyc, last_iv_cyc + 1);
    chk({tag, " res"}, res_seen, exp_of(v));
    chk({tag, " res_held"}, res_hold, exp_of(v));
    chk({tag, " busy_after_out"}, busy_after, 0);
    if (!v.gaps) chk({tag, " res_valid_cycle"}, rv_cyc, swap_cyc + NODE + 3);
  endtask

  initial begin
    int rq;
    int rv;
    int dr;

    vecs[0] = '{pix: 1,   wt_even: 1,    wt_odd: 1,    gaps: 0, extra_swap: 0, exp: 784};
    vecs[1] = '{pix: 255, wt_even: -128, wt_odd: -128, gaps: 0, extra_swap: 0, exp: -25589760};
    vecs[2] = '{pix: 255, wt_even: 127,  wt_odd: 127,  gaps: 1, extra_swap: 0, exp: 25389840};
    vecs[3] = '{pix: 2,   wt_even: -3,   wt_odd: -3,   gaps: 0, extra_swap: 1, exp: -4704};
    vecs[4] = '{pix: 3,   wt_even: 1,    wt_odd: -2,   gaps: 1, extra_swap: 0, exp: -1176};
    vecs[5] = '{pix: 0,   wt_even: -128, wt_odd: -128, gaps: 0, extra_swap: 0, exp: 0};

    rst = 1'b0;
    pingpong_swap = 1'b0;
    i_valid = 1'b0;
    i_din = '0;
    wt_data = '0;
    repeat (3) step();
    chk("reset r_request", longint'(r_request), 0);
    chk("reset wt_addr", longint'(wt_addr), 0);
    chk("reset res_valid", longint'(res_valid), 0);
    chk("reset res", longint'(res), 0);
    chk("reset busy", longint'(busy), 1);
    chk("reset done_read", longint'(done_read), 0);

    rst = 1'b1;
    #1;
    chk("release done_read", longint'(done_read), 1);
    step();
    chk("idle done_read", longint'(done_read), 0);
    rq = 0;
    repeat (4) begin
      step();
      if (r_request) rq++;
    end
    chk("idle no r_request", rq, 0);
    chk("idle busy", longint'(busy), 0);

    for (int i = 0; i < 6; i++) begin
      // Stray element while idle must not disturb the next frame.
      i_valid = 1'b1;
      i_din = 8'd55;
      wt_data = 8'd9;
      step();
      i_valid = 1'b0;
      step();
      run_frame(vecs[i], -1);
      check_frame($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset at request 400 abandons the frame.
    step();
    run_frame(vecs[0], 400);
    rv = 0;
    dr = 0;
    repeat (3) begin
      step();
      if (res_valid) rv++;
      if (done_read) dr++;
    end
    chk("abort res_valid", n_rv + rv, 0);
    chk("abort done_read in reset", dr, 0);
    chk("abort busy in reset", longint'(busy), 1);
    chk("abort r_request in reset", longint'(r_request), 0);
    chk("abort res cleared", longint'(res), 0);
    rst = 1'b1;
    #1;
    chk("abort release done_read", longint'(done_read), 1);
    step();
    chk("abort post done_read", longint'(done_read), 0);
    chk("abort post busy", longint'(busy), 0);
    step();
    run_frame(vecs[1], -1);
    check_frame("after_abort", vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
